// File: rtl/jtframe_prog_pkg.sv
// jtframe_prog_pkg
// Shared types and constants for the ROM download packer.
//   prog_state_t : write-sequencer states (IDLE, WRITE, WAIT)
//   prog_entry_t : one buffered download byte, already bank-decoded
//   MASK_*       : active-low SDRAM byte enables
//   byte_mask()  : picks the byte lane from the byte-address LSB
package jtframe_prog_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    WAIT  = 2'd2
  } prog_state_t;

  // Active-low enables: a zero bit selects that byte lane.
  localparam logic [1:0] MASK_LO   = 2'b10;
  localparam logic [1:0] MASK_HI   = 2'b01;
  localparam logic [1:0] MASK_NONE = 2'b11;

  // addr holds the word offset inside the bank (byte offset [24:1]); the
  // top module trims it to the SDRAM word width when loading the outputs.
  typedef struct packed {
    logic [1:0]  ba;
    logic [23:0] addr;
    logic [1:0]  mask;
    logic [7:0]  data;
  } prog_entry_t;

  function automatic logic [1:0] byte_mask(input logic lsb);
    return lsb ? MASK_HI : MASK_LO;
  endfunction

endpackage

// File: rtl/jtframe_prog_fifo.sv
// jtframe_prog_fifo
// Two-entry FIFO with 1-bit read/write pointers and an occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write strobe and data
//   pop        : remove head entry (ignored when empty)
//   dout       : head entry
//   empty/full : occupancy flags
//   drop       : a push was refused because the FIFO was full
module jtframe_prog_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         drop
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         pop_ok;
  logic         accept;

  assign empty  = (count == 2'd0);
  assign full   = (count == 2'd2);
  assign pop_ok = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign accept = push & (~full | pop_ok);
  assign drop   = push & full & ~pop_ok;
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (accept) wr_ptr <= ~wr_ptr;
      if (pop_ok) rd_ptr <= ~rd_ptr;
      unique case ({accept, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/jtframe_prog_pack.sv
// jtframe_prog_pack
// Packs ROM-download bytes into SDRAM byte writes: decodes the bank from
// the byte address, buffers up to two bytes and replays them to the SDRAM
// controller with a prog_we / prog_rdy handshake.
//   clk, rst_n            : clock, asynchronous active-low reset
//   downloading           : download in progress
//   ioctl_addr/dout/wr    : byte address, byte and one-cycle strobe
//   prog_addr/data/mask/ba: SDRAM word address, {2{byte}}, byte enables, bank
//   prog_we, prog_rdy     : write request (held) and completion pulse
//   dwnld_busy            : download or pending writes still active
//   ovf                   : sticky overflow, cleared when a download starts
// Optional build macro JTFRAME_PROG_HEADER_EN: skip the first HEADER bytes
// and shift the remaining addresses down by HEADER.
module jtframe_prog_pack
  import jtframe_prog_pkg::*;
#(
  parameter int          SDRAMW    = 22,
  parameter logic [24:0] BA1_START = 25'h1FF_FFFF,
  parameter logic [24:0] BA2_START = 25'h1FF_FFFF,
  parameter logic [24:0] BA3_START = 25'h1FF_FFFF,
  parameter int          HEADER    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              downloading,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ioctl_wr,
  output logic [SDRAMW-1:0] prog_addr,
  output logic [15:0]       prog_data,
  output logic [1:0]        prog_mask,
  output logic [1:0]        prog_ba,
  output logic              prog_we,
  input  logic              prog_rdy,
  output logic              dwnld_busy,
  output logic              ovf
);

  logic [24:0] eff_addr;
  logic        byte_ok;

`ifdef JTFRAME_PROG_HEADER_EN
  assign byte_ok  = (ioctl_addr >= 25'(HEADER));
  assign eff_addr = ioctl_addr - 25'(HEADER);
`else
  logic unused_header;
  assign unused_header = ^25'(HEADER);
  assign byte_ok  = 1'b1;
  assign eff_addr = ioctl_addr;
`endif

  logic [1:0]  dec_ba;
  logic [24:0] dec_off;

  // Highest matching bank wins, so unused banks are parked at the top.
  always_comb begin
    dec_ba  = 2'd0;
    dec_off = eff_addr;
    if (eff_addr >= BA3_START) begin
      dec_ba  = 2'd3;
      dec_off = eff_addr - BA3_START;
    end else if (eff_addr >= BA2_START) begin
      dec_ba  = 2'd2;
      dec_off = eff_addr - BA2_START;
    end else if (eff_addr >= BA1_START) begin
      dec_ba  = 2'd1;
      dec_off = eff_addr - BA1_START;
    end
  end

  prog_entry_t new_entry;
  prog_entry_t head;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_drop;
  logic        fifo_pop;

  assign new_entry.ba   = dec_ba;
  assign new_entry.addr = dec_off[24:1];
  assign new_entry.mask = byte_mask(dec_off[0]);
  assign new_entry.data = ioctl_dout;

  jtframe_prog_fifo #(
    .W ($bits(prog_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ioctl_wr & byte_ok),
    .din   (new_entry),
    .pop   (fifo_pop),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .drop  (fifo_drop)
  );

  logic unused_fifo;
  assign unused_fifo = fifo_full ^ (^head.addr);

  prog_state_t state;
  prog_state_t next_state;
  logic        load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // The head entry stays in the FIFO until the controller acknowledges it.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    fifo_pop   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          next_state = WRITE;
          load       = 1'b1;
        end
      end
      WRITE: begin
        if (prog_rdy) begin
          fifo_pop   = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign prog_we = (state == WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_addr <= '0;
      prog_data <= 16'd0;
      prog_mask <= MASK_NONE;
      prog_ba   <= 2'd0;
    end else if (load) begin
      prog_addr <= head.addr[SDRAMW-1:0];
      prog_data <= {2{head.data}};
      prog_mask <= head.mask;
      prog_ba   <= head.ba;
    end
  end

  logic dl_last;

  // A drop in the same cycle as a new download start still leaves ovf set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf     <= 1'b0;
      dl_last <= 1'b0;
    end else begin
      dl_last <= downloading;
      if (downloading && !dl_last) ovf <= 1'b0;
      if (fifo_drop)               ovf <= 1'b1;
    end
  end

  assign dwnld_busy = downloading | ~fifo_empty | (state != IDLE);

endmodule

// File: tb/tb_jtframe_prog_pack.sv
// tb_jtframe_prog_pack
// Scoreboard bench for jtframe_prog_pack: each accepted byte pushes its
// expected SDRAM write; a responder acknowledges prog_we and pops/compares.
module tb_jtframe_prog_pack;

  localparam logic [24:0] BA1 = 25'h100000;
  localparam logic [24:0] BA2 = 25'h200000;
  localparam logic [24:0] BA3 = 25'h300000;
  localparam int          HDR = 16;
`ifdef JTFRAME_PROG_HEADER_EN
  localparam logic [24:0] HOFS = 25'd16;
`else
  localparam logic [24:0] HOFS = 25'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        downloading;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wr;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic [1:0]  prog_ba;
  logic        prog_we;
  logic        prog_rdy;
  logic        dwnld_busy;
  logic        ovf;

  always #5 clk = ~clk;

  jtframe_prog_pack #(
    .SDRAMW    (22),
    .BA1_START (BA1),
    .BA2_START (BA2),
    .BA3_START (BA3),
    .HEADER    (HDR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .ioctl_wr    (ioctl_wr),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_ba     (prog_ba),
    .prog_we     (prog_we),
    .prog_rdy    (prog_rdy),
    .dwnld_busy  (dwnld_busy),
    .ovf         (ovf)
  );

  typedef struct packed {
    logic [1:0]  ba;
    logic [21:0] addr;
    logic [1:0]  mask;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        ovf_exp;
  logic        hold_rdy;
  int          rdy_after;
  int          we_cnt;
  logic [24:0] tbl [5];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    ioctl_wr = 1'b0;
  endtask

  // Drive one byte in the current cycle and predict its SDRAM write.
  task automatic pushByte(input logic [24:0] a, input logic [7:0] d);
    exp_t        e;
    logic [24:0] eff;
    logic [24:0] off;
    logic        ok;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    ok  = 1'b1;
    eff = a;
`ifdef JTFRAME_PROG_HEADER_EN
    if (a < 25'(HDR)) ok = 1'b0;
    eff = a - 25'(HDR);
`endif
    if (ok) begin
      if (sb.size() >= 2) begin
        ovf_exp = 1'b1;
      end else begin
        if (eff >= BA3)      begin e.ba = 2'd3; off = eff - BA3; end
        else if (eff >= BA2) begin e.ba = 2'd2; off = eff - BA2; end
        else if (eff >= BA1) begin e.ba = 2'd1; off = eff - BA1; end
        else                 begin e.ba = 2'd0; off = eff;       end
        e.addr = off[22:1];
        e.mask = off[0] ? 2'b01 : 2'b10;
        e.data = {d, d};
        sb.push_back(e);
      end
    end
  endtask

  task automatic applyStimulus(input logic [24:0] a, input logic [7:0] d);
    tick();
    pushByte(a, d);
  endtask

  task automatic setDownloading(input logic v);
    tick();
    if (v && !downloading) ovf_exp = 1'b0;
    downloading = v;
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    checkOutput("drained", sb.size(), 0);
    repeat (5) tick();
  endtask

  // SDRAM controller model: acknowledges after rdy_after+1 cycles of prog_we.
  initial begin
    exp_t e;
    prog_rdy = 1'b0;
    we_cnt   = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prog_rdy = 1'b0;
        we_cnt   = 0;
      end else begin
        if (prog_rdy) checkOutput("we_after_rdy", prog_we, 0);
        prog_rdy = 1'b0;
        if (prog_we && !hold_rdy) begin
          we_cnt++;
          if (we_cnt > rdy_after) begin
            checkOutput("write_expected", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
              e = sb.pop_front();
              checkOutput("wr_ba",   prog_ba,   e.ba);
              checkOutput("wr_addr", prog_addr, e.addr);
              checkOutput("wr_mask", prog_mask, e.mask);
              checkOutput("wr_data", prog_data, e.data);
            end
            prog_rdy = 1'b1;
            we_cnt   = 0;
          end
        end else if (!prog_we) begin
          if (we_cnt != 0) checkOutput("we_early_drop", we_cnt, 0);
          we_cnt = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  n;
    int  w;
    int  seen;
    logic found;
    rst_n       = 1'b0;
    downloading = 1'b0;
    ioctl_wr    = 1'b0;
    ioctl_addr  = '0;
    ioctl_dout  = '0;
    hold_rdy    = 1'b0;
    rdy_after   = 3;
    ovf_exp     = 1'b0;
    tbl[0] = 25'h100004;
    tbl[1] = 25'h0FFFFF;
    tbl[2] = 25'h200000;
    tbl[3] = 25'h3000FF;
    tbl[4] = 25'h1FFFFFF;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_we",   prog_we,    0);
    checkOutput("rst_addr", prog_addr,  0);
    checkOutput("rst_data", prog_data,  0);
    checkOutput("rst_mask", prog_mask,  2'b11);
    checkOutput("rst_ba",   prog_ba,    0);
    checkOutput("rst_ovf",  ovf,        0);
    checkOutput("rst_busy", dwnld_busy, 0);
    rst_n = 1'b1;

    // Single byte: latency, pulse width and literal output values
    $display("[TB] single byte write");
    setDownloading(1'b1);
    applyStimulus(HOFS + 25'h3, 8'hA5);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n++;
      if (prog_we) break;
    end
    checkOutput("we_latency", n, 2);
    checkOutput("lit_addr", prog_addr, 22'd1);
    checkOutput("lit_mask", prog_mask, 2'b01);
    checkOutput("lit_data", prog_data, 16'hA5A5);
    checkOutput("lit_ba",   prog_ba,   2'd0);
    w = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!prog_we) break;
      w++;
    end
    checkOutput("we_width", w, 4);
    waitDrain(50);

    // Bank decode table
    $display("[TB] bank decode");
    rdy_after = 1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(HOFS + tbl[i], 8'h10 + 8'(i));
      waitDrain(50);
    end

    // Overflow with acknowledge withheld
    $display("[TB] overflow");
    rdy_after = 2;
    hold_rdy  = 1'b1;
    applyStimulus(25'h40, 8'h01);
    applyStimulus(25'h41, 8'h02);
    applyStimulus(25'h42, 8'h03);
    tick();
    tick();
    checkOutput("ovf_set", ovf, ovf_exp);
    hold_rdy = 1'b0;
    waitDrain(60);
    checkOutput("ovf_sticky", ovf, ovf_exp);
    setDownloading(1'b0);
    setDownloading(1'b1);
    tick();
    checkOutput("ovf_clear", ovf, ovf_exp);

    // Push in the same cycle as the acknowledge of the only entry
    $display("[TB] simultaneous push and pop");
    applyStimulus(25'h80, 8'h5A);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (prog_rdy) begin
        hold_rdy = 1'b1;
        pushByte(25'h81, 8'h6B);
        found = 1'b1;
        break;
      end
    end
    checkOutput("simul_rdy_seen", found, 1);
    applyStimulus(25'h82, 8'h7C);
    tick();
    tick();
    checkOutput("ovf_simul", ovf, ovf_exp);
    hold_rdy = 1'b0;
    waitDrain(60);

    // Download ends while writes are still pending
    $display("[TB] drain after download end");
    hold_rdy = 1'b1;
    applyStimulus(25'h50, 8'h91);
    applyStimulus(25'h51, 8'h92);
    tick();
    downloading = 1'b0;
    tick();
    tick();
    checkOutput("busy_drain", dwnld_busy, 1);
    hold_rdy = 1'b0;
    waitDrain(60);
    checkOutput("busy_done", dwnld_busy, 0);

    // Header boundary
    $display("[TB] header boundary");
    rdy_after = 0;
    setDownloading(1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(25'd14 + 25'(i), 8'hC0 + 8'(i));
      waitDrain(50);
    end

    // Reset during a write
    $display("[TB] reset mid-write");
    hold_rdy = 1'b1;
    applyStimulus(25'h60, 8'hEE);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (prog_we) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("mid_we_seen", found, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_we",   prog_we,   0);
    checkOutput("mid_rst_mask", prog_mask, 2'b11);
    checkOutput("mid_rst_addr", prog_addr, 0);
    sb.delete();
    ovf_exp = 1'b0;
    tick();
    tick();
    rst_n    = 1'b1;
    hold_rdy = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (prog_we) seen++;
    end
    checkOutput("no_we_after_rst", seen, 0);
    checkOutput("busy_eq_dl1", dwnld_busy, downloading);
    downloading = 1'b0;
    tick();
    checkOutput("busy_eq_dl0", dwnld_busy, downloading);
    checkOutput("ovf_after_rst", ovf, ovf_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
